// File: rtl/codon_scan_scheduler_if.sv
// Scheduler-side bundle: control, gene/codon memory reads, unit start/done and result handshake.
// The scheduler takes the master modport; the surrounding system (or a bench) takes the slave modport.
interface codon_scan_scheduler_if #(
  parameter int GENE_MEM_DEPTH  = 256,
  parameter int ELEMENT_COUNT   = 32,
  parameter int PROC_UNIT_COUNT = GENE_MEM_DEPTH / ELEMENT_COUNT,
  parameter int MAX_CODONS      = 6,
  parameter int MAX_COUNT       = 16,
  parameter int CODON_MEM_DEPTH = 32
) ();
  localparam int CW  = $clog2(MAX_COUNT + 1);
  localparam int NW  = $clog2(MAX_CODONS + 1);
  localparam int GAW = $clog2(GENE_MEM_DEPTH);
  localparam int CAW = $clog2(CODON_MEM_DEPTH);

  logic                          START;
  logic [NW-1:0]                 NUM_CODONS;
  logic                          BUSY;
  logic                          DONE;
  logic                          GENE_RD_EN;
  logic [GAW-1:0]                GENE_RD_ADDR;
  logic [PROC_UNIT_COUNT-1:0]    SEG_LOAD;
  logic                          CODON_RD_EN;
  logic [CAW-1:0]                CODON_RD_ADDR;
  logic                          PU_START;
  logic [PROC_UNIT_COUNT-1:0]    PU_DONE;
  logic [PROC_UNIT_COUNT*CW-1:0] PU_COUNT;
  logic                          RESULT_VALID;
  logic                          RESULT_READY;
  logic [CAW-1:0]                RESULT_CODON;
  logic [CW-1:0]                 RESULT_COUNT;
  logic                          ERR;

  modport master (
    input  START, NUM_CODONS, PU_DONE, PU_COUNT, RESULT_READY,
    output BUSY, DONE, GENE_RD_EN, GENE_RD_ADDR, SEG_LOAD, CODON_RD_EN, CODON_RD_ADDR,
           PU_START, RESULT_VALID, RESULT_CODON, RESULT_COUNT, ERR
  );

  modport slave (
    output START, NUM_CODONS, PU_DONE, PU_COUNT, RESULT_READY,
    input  BUSY, DONE, GENE_RD_EN, GENE_RD_ADDR, SEG_LOAD, CODON_RD_EN, CODON_RD_ADDR,
           PU_START, RESULT_VALID, RESULT_CODON, RESULT_COUNT, ERR
  );
endinterface

// File: rtl/codon_scan_scheduler.sv
// Whole-genome codon scan sequencer: segment load, per-codon unit run, saturated gather, result handshake.
// Optional RUN watchdog enabled by defining SCHED_TIMEOUT_EN (sets ERR and reports the partial total).
//
// state      | meaning
// IDLE       | waiting for START
// LOAD_SEG   | reading segment u from gene memory, one unit per cycle
// LOAD_CODON | reading codon c from codon memory
// RUN        | first cycle pulses PU_START, then gathers PU_DONE/PU_COUNT
// REPORT     | holding result until RESULT_READY
module codon_scan_scheduler #(
  parameter int ELEMENT_COUNT   = 32,
  parameter int GENE_MEM_DEPTH  = 256,
  parameter int PROC_UNIT_COUNT = GENE_MEM_DEPTH / ELEMENT_COUNT,
  parameter int MAX_CODONS      = 6,
  parameter int MAX_COUNT       = 16,
  parameter int CODON_MEM_DEPTH = 32,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input logic                    CLK,
  input logic                    RST_N,
  codon_scan_scheduler_if.master bus
);
  localparam int P   = PROC_UNIT_COUNT;
  localparam int CW  = $clog2(MAX_COUNT + 1);
  localparam int NW  = $clog2(MAX_CODONS + 1);
  localparam int GAW = $clog2(GENE_MEM_DEPTH);
  localparam int CAW = $clog2(CODON_MEM_DEPTH);
  localparam int UW  = (P > 1) ? $clog2(P) : 1;
  // wide enough for the accumulator plus every unit's full-scale count in one cycle
  localparam int SW  = CW + $clog2(P + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_SEG, S_LOAD_CODON, S_RUN, S_REPORT
  } state_t;

  state_t         state_q, state_d;
  logic [UW-1:0]  u_q;
  logic [NW-1:0]  c_q;
  logic [NW-1:0]  n_q;
  logic [P-1:0]   pending_q;
  logic [CW-1:0]  acc_q;
  logic           run_first_q;
  logic [P-1:0]   seg_load_q;
  logic           done_q;
  logic           err_q;

  logic [NW-1:0]  num_clamped;
  logic           seg_last;
  logic           codon_last;
  logic           handshake;
  logic [P-1:0]   hit;
  logic [P-1:0]   pending_nx;
  logic [SW-1:0]  sum_wide;
  logic [CW-1:0]  acc_nx;
  logic           timeout_hit;

  assign num_clamped = (bus.NUM_CODONS > NW'(MAX_CODONS)) ? NW'(MAX_CODONS) : bus.NUM_CODONS;
  assign seg_last    = (u_q == UW'(P - 1));
  assign codon_last  = (c_q == n_q - NW'(1));
  assign handshake   = (state_q == S_REPORT) && bus.RESULT_READY;
  // completions during the PU_START cycle belong to no run and are dropped
  assign hit         = run_first_q ? '0 : (pending_q & bus.PU_DONE);
  assign pending_nx  = pending_q & ~hit;

  always_comb begin
    sum_wide = SW'(acc_q);
    for (int i = 0; i < P; i++) begin
      if (hit[i]) sum_wide = sum_wide + SW'(bus.PU_COUNT[i*CW +: CW]);
    end
    acc_nx = (sum_wide > SW'(MAX_COUNT)) ? CW'(MAX_COUNT) : sum_wide[CW-1:0];
  end

`ifdef SCHED_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] run_cnt_q;

  assign timeout_hit = (state_q == S_RUN) && (run_cnt_q == '0) && (pending_nx != '0);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      run_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (state_q == S_LOAD_CODON) run_cnt_q <= TW'(TIMEOUT_CYCLES - 1);
      else if (state_q == S_RUN && run_cnt_q != '0) run_cnt_q <= run_cnt_q - 1'b1;
      if (state_q == S_IDLE && bus.START) err_q <= 1'b0;
      else if (timeout_hit) err_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_q       = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       if (bus.START && num_clamped != '0) state_d = S_LOAD_SEG;
      S_LOAD_SEG:   if (seg_last) state_d = S_LOAD_CODON;
      S_LOAD_CODON: state_d = S_RUN;
      S_RUN:        if (pending_nx == '0 || timeout_hit) state_d = S_REPORT;
      S_REPORT:     if (handshake) state_d = codon_last ? S_IDLE : S_LOAD_CODON;
      default:      state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      u_q         <= '0;
      c_q         <= '0;
      n_q         <= '0;
      pending_q   <= '0;
      acc_q       <= '0;
      run_first_q <= 1'b0;
      seg_load_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      seg_load_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (bus.START) begin
            if (num_clamped == '0) begin
              done_q <= 1'b1;
            end else begin
              n_q <= num_clamped;
              u_q <= '0;
              c_q <= '0;
            end
          end
        end
        S_LOAD_SEG: begin
          // gene memory has one cycle of read latency, so the capture strobe trails the read
          seg_load_q <= P'(1) << u_q;
          u_q        <= seg_last ? '0 : u_q + 1'b1;
        end
        S_LOAD_CODON: begin
          pending_q   <= '1;
          acc_q       <= '0;
          run_first_q <= 1'b1;
        end
        S_RUN: begin
          run_first_q <= 1'b0;
          pending_q   <= pending_nx;
          acc_q       <= acc_nx;
        end
        S_REPORT: begin
          if (handshake) begin
            if (codon_last) done_q <= 1'b1;
            else            c_q    <= c_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.BUSY          = (state_q != S_IDLE);
    bus.GENE_RD_EN    = 1'b0;
    bus.GENE_RD_ADDR  = '0;
    bus.CODON_RD_EN   = 1'b0;
    bus.CODON_RD_ADDR = '0;
    bus.PU_START      = 1'b0;
    bus.RESULT_VALID  = 1'b0;
    bus.RESULT_CODON  = '0;
    bus.RESULT_COUNT  = '0;
    case (state_q)
      S_LOAD_SEG: begin
        bus.GENE_RD_EN   = 1'b1;
        bus.GENE_RD_ADDR = GAW'(int'(u_q) * ELEMENT_COUNT);
      end
      S_LOAD_CODON: begin
        bus.CODON_RD_EN   = 1'b1;
        bus.CODON_RD_ADDR = CAW'(c_q);
      end
      S_RUN: bus.PU_START = run_first_q;
      S_REPORT: begin
        bus.RESULT_VALID = 1'b1;
        bus.RESULT_CODON = CAW'(c_q);
        bus.RESULT_COUNT = acc_q;
      end
      default: ;
    endcase
  end

  assign bus.SEG_LOAD = seg_load_q;
  assign bus.DONE     = done_q;
  assign bus.ERR      = err_q;

endmodule

// File: doc/codon_scan_scheduler.md
# codon_scan_scheduler

Sequences one whole-genome codon search across the processing-unit array. It loads each unit's gene segment from gene memory, then steps through the codon list one codon at a time. For each codon it starts all units and gathers their per-unit match counts into one saturated total, which it reports to the result consumer under a valid/ready handshake. It sits between the top-level control (buttons/switches) and the gene memory, codon memory and processing units.

## Interface
Parameters:
- ELEMENT_COUNT, 32, elements per processing-unit segment (segment stride in gene memory)
- GENE_MEM_DEPTH, 256, gene memory depth in elements
- PROC_UNIT_COUNT, GENE_MEM_DEPTH / ELEMENT_COUNT, number of processing units
- MAX_CODONS, 6, maximum codons per scan
- MAX_COUNT, 16, saturation value of every count; CW = $clog2(MAX_COUNT+1)
- CODON_MEM_DEPTH, 32, codon memory depth
- TIMEOUT_CYCLES, 1024, RUN watchdog limit (used only with SCHED_TIMEOUT_EN)

Ports:
- CLK  in  1  clock
- RST_N  in  1  reset: one clock; reset is asynchronous and active-low
- START  in  1  begin scan; sampled only in IDLE
- NUM_CODONS  in  $clog2(MAX_CODONS+1)  codons to scan; latched on START, clamped to MAX_CODONS
- BUSY  out  1  high in any state except IDLE
- DONE  out  1  one-cycle pulse at scan end
- GENE_RD_EN  out  1  gene memory segment read strobe
- GENE_RD_ADDR  out  $clog2(GENE_MEM_DEPTH)  segment base = u*ELEMENT_COUNT
- SEG_LOAD  out  PROC_UNIT_COUNT  one-hot; unit u captures read data
- CODON_RD_EN  out  1  codon memory read strobe
- CODON_RD_ADDR  out  $clog2(CODON_MEM_DEPTH)  current codon index c
- PU_START  out  1  broadcast start pulse to all units
- PU_DONE  in  PROC_UNIT_COUNT  per-unit completion pulse
- PU_COUNT  in  PROC_UNIT_COUNT*CW  per-unit match count; unit i in slice [i*CW +: CW], valid with PU_DONE[i]
- RESULT_VALID  out  1  result available
- RESULT_READY  in  1  consumer accepts
- RESULT_CODON  out  $clog2(CODON_MEM_DEPTH)  codon index of result
- RESULT_COUNT  out  CW  saturated total over all units
- ERR  out  1  timeout flag (constant 0 without SCHED_TIMEOUT_EN)

## Operation
- Reset: state IDLE. All outputs 0. Counters, pending mask and accumulator cleared. Applies immediately, including mid-scan; no DONE is issued.
- IDLE:
  - START with NUM_CODONS==0: DONE pulses next cycle; no memory or unit activity.
  - START with NUM_CODONS>0: latch n = min(NUM_CODONS, MAX_CODONS); set u=0, c=0; go to LOAD_SEG.
- LOAD_SEG: one cycle per unit, u = 0..PROC_UNIT_COUNT-1.
  - Each cycle: GENE_RD_EN=1, GENE_RD_ADDR=u*ELEMENT_COUNT.
  - SEG_LOAD[u] is registered and asserts the following cycle, matching the 1-cycle read latency.
  - After u=PROC_UNIT_COUNT-1, go to LOAD_CODON.
- LOAD_CODON: one cycle; CODON_RD_EN=1, CODON_RD_ADDR=c; then go to RUN.
- RUN:
  - First cycle: PU_START=1, pending mask set to all ones, accumulator = 0.
  - Each cycle, for every i with PU_DONE[i] high and pending[i] set: add PU_COUNT slice i, clear pending[i].
  - Adds from several units in the same cycle are summed in that cycle.
  - Sum saturates at MAX_COUNT.
  - PU_DONE on a non-pending unit, or during the PU_START cycle, is ignored.
  - When pending reaches 0, go to REPORT.
- REPORT:
  - RESULT_VALID=1; RESULT_CODON=c, RESULT_COUNT=acc, both held stable until RESULT_READY.
  - On handshake with c==n-1: DONE pulses, go to IDLE.
  - On handshake otherwise: c++, go to LOAD_CODON. Segments are not reloaded.
- START while BUSY is ignored.

## Timing
- START sampled at edge 0. GENE_RD_EN high in cycles 1..PROC_UNIT_COUNT. SEG_LOAD[u] high in cycle u+2.
- CODON_RD_EN in cycle PROC_UNIT_COUNT+1; PU_START in cycle PROC_UNIT_COUNT+2.
- If all PU_DONE arrive in cycle k, RESULT_VALID rises in cycle k+1.
- RESULT_READY high in the REPORT entry cycle completes the transfer in that cycle.
- Per-codon overhead excluding unit runtime and handshake wait: 3 cycles (LOAD_CODON, PU_START, REPORT).
- DONE is asserted in the cycle after the final handshake, with BUSY low in the same cycle.

## Configuration
- SCHED_TIMEOUT_EN defined:
  - A RUN cycle counter is active.
  - If RUN lasts TIMEOUT_CYCLES cycles with units still pending, go to REPORT with the partial accumulator and set ERR=1.
  - ERR stays set until the next accepted START.
- SCHED_TIMEOUT_EN undefined: no counter; RUN waits indefinitely; ERR tied 0.

## Test plan
- Reset mid-RUN (RST_N low for 1 cycle) -> all outputs 0 immediately; no DONE; next START runs normally from c=0.
- NUM_CODONS=0, START -> DONE one cycle later; GENE_RD_EN, CODON_RD_EN and PU_START never asserted.
- NUM_CODONS=2, each unit returns PU_COUNT=1 one cycle after PU_START, RESULT_READY=1 -> 8 GENE_RD_EN at addresses 0,32,...,224; results (0,8) then (1,8); DONE; no second segment load.
- All 8 units PU_DONE in the same cycle with PU_COUNT=3 -> RESULT_COUNT=16 (saturated). Unit 5 pulsing PU_DONE twice -> counted once.
- RESULT_READY held low 10 cycles in REPORT -> RESULT_VALID, RESULT_CODON and RESULT_COUNT stable; START pulses meanwhile ignored.
- SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=20, unit 7 never done, other units PU_COUNT=2 -> report after 20 RUN cycles with RESULT_COUNT=14, ERR=1; ERR clears on next START.
